// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline sequencer.
//  - pipe_state_e : data-memory wait FSM states
//  - FWD_*        : operand source select encoding (regfile / MEM result / WB result)
//  - stage_dst_t  : destination register + write-back enable of a pipeline stage
//  - reg_match    : true when a source register is written by a stage
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 4;
    localparam int unsigned FWD_W = 2;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } pipe_state_e;

    localparam logic [FWD_W-1:0] FWD_REG = 2'd0;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'd1;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wb_en;
    } stage_dst_t;

    function automatic logic reg_match(input logic [REG_W-1:0] src, input stage_dst_t dst);
        return dst.wb_en && (src == dst.dest);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational RAW comparators and operand forwarding selects.
// Build option: FORWARDING_EN
//   defined   : only a load in EXE causes a hazard; MEM/WB results are forwarded
//   undefined : any EXE/MEM writer of a source causes a hazard; selects stay at regfile
// Ports:
//   id_valid, id_src1, id_src2, id_two_src  ID instruction and its sources
//   exe_*/mem_*/wb_*                        destination info of later stages
//   raw_c                                   RAW hazard on the ID instruction
//   fwd_sel_a_c / fwd_sel_b_c               Val_Rn / Val_Rm source select
module hazard_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_wb_en,
    output logic             raw_c,
    output logic [FWD_W-1:0] fwd_sel_a_c,
    output logic [FWD_W-1:0] fwd_sel_b_c
);

    stage_dst_t exe_d;
    stage_dst_t mem_d;
    stage_dst_t wb_d;
    logic       hit1;
    logic       hit2;

    assign exe_d = '{dest: exe_dest, wb_en: exe_wb_en};
    assign mem_d = '{dest: mem_dest, wb_en: mem_wb_en};
    assign wb_d  = '{dest: wb_dest,  wb_en: wb_wb_en};

`ifdef FORWARDING_EN
    // Only a load in EXE cannot be forwarded; MEM has priority over WB.
    always_comb begin
        hit1        = exe_mem_r_en && reg_match(id_src1, exe_d);
        hit2        = exe_mem_r_en && reg_match(id_src2, exe_d);
        fwd_sel_a_c = FWD_REG;
        fwd_sel_b_c = FWD_REG;
        if (id_valid) begin
            if (reg_match(id_src1, mem_d))     fwd_sel_a_c = FWD_MEM;
            else if (reg_match(id_src1, wb_d)) fwd_sel_a_c = FWD_WB;
            if (id_two_src) begin
                if (reg_match(id_src2, mem_d))     fwd_sel_b_c = FWD_MEM;
                else if (reg_match(id_src2, wb_d)) fwd_sel_b_c = FWD_WB;
            end
        end
    end
`else
    // WB writes the regfile in the first half cycle, so only EXE/MEM conflict.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{wb_d, exe_mem_r_en};

    always_comb begin
        hit1        = reg_match(id_src1, exe_d) || reg_match(id_src1, mem_d);
        hit2        = reg_match(id_src2, exe_d) || reg_match(id_src2, mem_d);
        fwd_sel_a_c = FWD_REG;
        fwd_sel_b_c = FWD_REG;
    end
`endif

    assign raw_c = id_valid && (hit1 || (id_two_src && hit2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage ARM core: RAW bubble, IF freeze, branch
// flush, data-memory wait FSM and saturating stall/flush counters.
// Build option: FORWARDING_EN (see hazard_fwd_unit).
// Ports:
//   clk, rst (async, active-low)
//   id_*, exe_*, mem_*, wb_*    stage register info for hazard detection
//   exe_branch                  taken branch resolved in EXE
//   mem_req / mem_ready         MEM stage access request / SRAM completion
//   hazard, freeze_if, freeze_pipe, flush, mem_start, fwd_sel_a/b  control (combinational)
//   stall_count, flush_count    saturating performance counters
//   timeout_err                 sticky MEM_WAIT timeout flag
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic [3:0]       wb_dest,
    input  logic             wb_wb_en,
    input  logic             exe_branch,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             hazard,
    output logic             freeze_if,
    output logic             freeze_pipe,
    output logic             flush,
    output logic             mem_start,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             timeout_err
);

    localparam int unsigned      WAIT_W    = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              start_c;
    logic              frz_c;
    logic              timeout_set_c;
    logic              raw_c;
    logic [FWD_W-1:0]  fwd_a_c;
    logic [FWD_W-1:0]  fwd_b_c;

    hazard_fwd_unit u_hazard_fwd (
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .wb_dest      (wb_dest),
        .wb_wb_en     (wb_wb_en),
        .raw_c        (raw_c),
        .fwd_sel_a_c  (fwd_a_c),
        .fwd_sel_b_c  (fwd_b_c)
    );

    // Memory wait FSM: next state and freeze/start decode.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        start_c       = 1'b0;
        frz_c         = 1'b0;
        timeout_set_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_req) begin
                    start_c = 1'b1;
                    frz_c   = 1'b1;
                    wait_d  = '0;
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                wait_d = wait_q + WAIT_W'(1);
                if (mem_ready) begin
                    state_d = ST_RUN;
                end else if (wait_q == WAIT_LAST) begin
                    // Give up on the SRAM and let the pipe move on.
                    timeout_set_c = 1'b1;
                    state_d       = ST_RUN;
                end else begin
                    frz_c = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Control outputs are forced low while reset is asserted.
    assign mem_start   = rst && start_c;
    assign freeze_pipe = rst && frz_c;
    assign flush       = rst && exe_branch && !frz_c;
    assign hazard      = rst && raw_c && !flush;
    assign freeze_if   = hazard || freeze_pipe;
    assign fwd_sel_a   = rst ? fwd_a_c : FWD_REG;
    assign fwd_sel_b   = rst ? fwd_b_c : FWD_REG;

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Saturating perf counters and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (freeze_if && (stall_count != CNT_MAX)) stall_count <= stall_count + CNT_W'(1);
            if (flush && (flush_count != CNT_MAX))     flush_count <= flush_count + CNT_W'(1);
            if (timeout_set_c)                         timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed table, corner sequences
// and randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TMO  = 4;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic       id_valid;
        logic [3:0] id_src1;
        logic [3:0] id_src2;
        logic       id_two_src;
        logic [3:0] exe_dest;
        logic       exe_wb_en;
        logic       exe_mem_r_en;
        logic [3:0] mem_dest;
        logic       mem_wb_en;
        logic [3:0] wb_dest;
        logic       wb_wb_en;
        logic       exe_branch;
        logic       mem_req;
        logic       mem_ready;
    } in_t;

    typedef struct packed {
        in_t  in;
        logic hz_base;
        logic hz_fwd;
        logic fl;
    } vec_t;

    logic          clk;
    logic          rst;
    in_t           vin;
    logic          hazard, freeze_if, freeze_pipe, flush, mem_start, timeout_err;
    logic [1:0]    fwd_sel_a, fwd_sel_b;
    logic [CW-1:0] stall_count, flush_count;

    int n_vec;
    int n_err;

    // reference model state
    bit m_busy;
    bit m_terr;
    int m_waited;
    int m_stalls;
    int m_flushes;
    bit e_fif;
    bit e_fl;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (vin.id_valid),
        .id_src1      (vin.id_src1),
        .id_src2      (vin.id_src2),
        .id_two_src   (vin.id_two_src),
        .exe_dest     (vin.exe_dest),
        .exe_wb_en    (vin.exe_wb_en),
        .exe_mem_r_en (vin.exe_mem_r_en),
        .mem_dest     (vin.mem_dest),
        .mem_wb_en    (vin.mem_wb_en),
        .wb_dest      (vin.wb_dest),
        .wb_wb_en     (vin.wb_wb_en),
        .exe_branch   (vin.exe_branch),
        .mem_req      (vin.mem_req),
        .mem_ready    (vin.mem_ready),
        .hazard       (hazard),
        .freeze_if    (freeze_if),
        .freeze_pipe  (freeze_pipe),
        .flush        (flush),
        .mem_start    (mem_start),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_count  (stall_count),
        .flush_count  (flush_count),
        .timeout_err  (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic bit src_hit(input logic [3:0] s, input in_t x);
`ifdef FORWARDING_EN
        return x.exe_mem_r_en && x.exe_wb_en && (x.exe_dest == s);
`else
        return (x.exe_wb_en && (x.exe_dest == s)) || (x.mem_wb_en && (x.mem_dest == s));
`endif
    endfunction

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd_exp(input logic [3:0] s, input bit used, input in_t x);
        if (!x.id_valid || !used) return 2'd0;
        if (x.mem_wb_en && (x.mem_dest == s)) return 2'd1;
        if (x.wb_wb_en && (x.wb_dest == s)) return 2'd2;
        return 2'd0;
    endfunction
`endif

    function automatic in_t mkin(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                                 input logic two, input logic [3:0] ed, input logic ewb,
                                 input logic emr, input logic [3:0] md, input logic mwb,
                                 input logic [3:0] wd, input logic wwb, input logic br);
        in_t x = '0;
        x.id_valid     = v;
        x.id_src1      = s1;
        x.id_src2      = s2;
        x.id_two_src   = two;
        x.exe_dest     = ed;
        x.exe_wb_en    = ewb;
        x.exe_mem_r_en = emr;
        x.mem_dest     = md;
        x.mem_wb_en    = mwb;
        x.wb_dest      = wd;
        x.wb_wb_en     = wwb;
        x.exe_branch   = br;
        return x;
    endfunction

    // Drive one cycle of inputs and compare every output with the model.
    task automatic apply(input in_t x);
        bit         e_frz, e_start, e_raw, e_hz;
        logic [1:0] e_fa, e_fb;
        vin = x;
        #1;
        e_start = !m_busy && x.mem_req;
        e_frz   = m_busy ? !(x.mem_ready || (m_waited == int'(TMO) - 1)) : x.mem_req;
        e_raw   = x.id_valid && (src_hit(x.id_src1, x) || (x.id_two_src && src_hit(x.id_src2, x)));
        e_fl    = x.exe_branch && !e_frz;
        e_hz    = e_raw && !e_fl;
        e_fif   = e_hz || e_frz;
`ifdef FORWARDING_EN
        e_fa = fwd_exp(x.id_src1, 1'b1, x);
        e_fb = fwd_exp(x.id_src2, x.id_two_src, x);
`else
        e_fa = 2'd0;
        e_fb = 2'd0;
`endif
        chk("hazard",      32'(hazard),      32'(e_hz));
        chk("freeze_if",   32'(freeze_if),   32'(e_fif));
        chk("freeze_pipe", 32'(freeze_pipe), 32'(e_frz));
        chk("flush",       32'(flush),       32'(e_fl));
        chk("mem_start",   32'(mem_start),   32'(e_start));
        chk("fwd_sel_a",   32'(fwd_sel_a),   32'(e_fa));
        chk("fwd_sel_b",   32'(fwd_sel_b),   32'(e_fb));
        chk("stall_count", 32'(stall_count), 32'(sat(m_stalls)));
        chk("flush_count", 32'(flush_count), 32'(sat(m_flushes)));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    // Advance one clock edge, updating the model from the applied inputs.
    task automatic tick();
        @(posedge clk);
        m_stalls  += int'(e_fif);
        m_flushes += int'(e_fl);
        if (m_busy) begin
            if (vin.mem_ready) begin
                m_busy = 1'b0;
            end else if (m_waited == int'(TMO) - 1) begin
                m_terr = 1'b1;
                m_busy = 1'b0;
            end else begin
                m_waited++;
            end
        end else if (vin.mem_req) begin
            m_busy   = 1'b1;
            m_waited = 0;
        end
        @(negedge clk);
    endtask

    // Assert reset with the given inputs held; everything must read 0.
    task automatic do_reset(input in_t x);
        vin = x;
        rst = 1'b0;
        #1;
        chk("rst_hazard",      32'(hazard),      32'd0);
        chk("rst_freeze_if",   32'(freeze_if),   32'd0);
        chk("rst_freeze_pipe", 32'(freeze_pipe), 32'd0);
        chk("rst_flush",       32'(flush),       32'd0);
        chk("rst_mem_start",   32'(mem_start),   32'd0);
        chk("rst_fwd_a",       32'(fwd_sel_a),   32'd0);
        chk("rst_fwd_b",       32'(fwd_sel_b),   32'd0);
        chk("rst_stall_count", 32'(stall_count), 32'd0);
        chk("rst_flush_count", 32'(flush_count), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        m_busy    = 1'b0;
        m_terr    = 1'b0;
        m_waited  = 0;
        m_stalls  = 0;
        m_flushes = 0;
        e_fif     = 1'b0;
        e_fl      = 1'b0;
        @(negedge clk);
        vin = '0;
        rst = 1'b1;
    endtask

    initial begin
        vec_t        tbl [10];
        in_t         x;
        in_t         x2;
        logic [31:0] r;
        logic        exp_hz;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        vin   = '0;

        //                 v  s1 s2 two ed ewb emr md mwb wd wwb br   base fwd fl
        tbl[0] = '{mkin(1, 3, 0, 0,  3, 1,  0,  0, 0,  0, 0,  0), 1'b1, 1'b0, 1'b0};
        tbl[1] = '{mkin(1, 3, 0, 0,  3, 0,  0,  0, 0,  0, 0,  0), 1'b0, 1'b0, 1'b0};
        tbl[2] = '{mkin(1, 7, 0, 0,  0, 0,  0,  7, 1,  0, 0,  0), 1'b1, 1'b0, 1'b0};
        tbl[3] = '{mkin(1, 1, 9, 0,  9, 1,  0,  0, 0,  0, 0,  0), 1'b0, 1'b0, 1'b0};
        tbl[4] = '{mkin(1, 1, 9, 1,  9, 1,  0,  0, 0,  0, 0,  0), 1'b1, 1'b0, 1'b0};
        tbl[5] = '{mkin(1, 1, 5, 1,  5, 1,  1,  0, 0,  0, 0,  0), 1'b1, 1'b1, 1'b0};
        tbl[6] = '{mkin(0, 3, 3, 1,  3, 1,  1,  3, 1,  0, 0,  0), 1'b0, 1'b0, 1'b0};
        tbl[7] = '{mkin(1, 6, 6, 1,  0, 0,  0,  0, 0,  6, 1,  0), 1'b0, 1'b0, 1'b0};
        tbl[8] = '{mkin(1, 3, 0, 0,  3, 1,  1,  0, 0,  0, 0,  1), 1'b0, 1'b0, 1'b1};
        tbl[9] = '{mkin(1, 2, 0, 0,  0, 0,  0,  0, 0,  0, 0,  1), 1'b0, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        do_reset('0);

        // directed combinational table
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].in);
`ifdef FORWARDING_EN
            exp_hz = tbl[i].hz_fwd;
`else
            exp_hz = tbl[i].hz_base;
`endif
            chk("tbl_hazard",    32'(hazard),    32'(exp_hz));
            chk("tbl_freeze_if", 32'(freeze_if), 32'(exp_hz));
            chk("tbl_flush",     32'(flush),     32'(tbl[i].fl));
            tick();
        end

        // load-use bubble
        do_reset('0);
        x = mkin(1, 0, 5, 1, 5, 1, 1, 0, 0, 0, 0, 0);
        apply(x);
        chk("lu_hazard", 32'(hazard), 32'd1);
        tick();
        apply('0);
        chk("lu_stall_count", 32'(stall_count), 32'd1);
        tick();

        // memory access, ready on the third wait cycle
        do_reset('0);
        x = '0;
        x.mem_req = 1'b1;
        apply(x);
        chk("ms_start",   32'(mem_start),   32'd1);
        chk("ms_freeze0", 32'(freeze_pipe), 32'd1);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(x);
            chk("ms_start_once",  32'(mem_start),   32'd0);
            chk("ms_freeze_wait", 32'(freeze_pipe), 32'd1);
            tick();
        end
        x.mem_ready = 1'b1;
        apply(x);
        chk("ms_release",    32'(freeze_pipe), 32'd0);
        chk("ms_no_restart", 32'(mem_start),   32'd0);
        tick();
        apply('0);
        chk("ms_stall_count", 32'(stall_count), 32'd3);
        tick();

        // branch over a hazard, then a branch held behind a memory wait
        do_reset('0);
        x = mkin(1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1);
        apply(x);
        chk("br_flush",     32'(flush),     32'd1);
        chk("br_hazard",    32'(hazard),    32'd0);
        chk("br_freeze_if", 32'(freeze_if), 32'd0);
        tick();
        apply('0);
        chk("br_flush_count", 32'(flush_count), 32'd1);
        tick();
        x = '0;
        x.mem_req = 1'b1;
        apply(x);
        tick();
        x.exe_branch = 1'b1;
        apply(x);
        chk("br_wait_no_flush", 32'(flush), 32'd0);
        tick();
        x.mem_ready = 1'b1;
        apply(x);
        chk("br_late_flush", 32'(flush), 32'd1);
        tick();
        apply('0);
        chk("br_flush_count2", 32'(flush_count), 32'd2);
        tick();

        // timeout with mem_ready stuck low
        do_reset('0);
        x = '0;
        x.mem_req = 1'b1;
        apply(x);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(x);
            chk("to_freeze", 32'(freeze_pipe), (i < 3) ? 32'd1 : 32'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            apply('0);
            chk("to_sticky", 32'(timeout_err), 32'd1);
            tick();
        end

        // reset in the middle of a wait
        do_reset('0);
        x = '0;
        x.mem_req = 1'b1;
        apply(x);
        tick();
        x2 = mkin(1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1);
        x2.mem_req = 1'b1;
        apply(x2);
        do_reset(x2);
        apply('0);
        chk("mr_no_start",  32'(mem_start),   32'd0);
        chk("mr_no_freeze", 32'(freeze_pipe), 32'd0);
        tick();
        apply(x);
        chk("mr_run_start", 32'(mem_start), 32'd1);
        tick();

        // counter saturation
        do_reset('0);
        x = mkin(1, 0, 5, 1, 5, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            apply(x);
            tick();
        end
        x = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            apply(x);
            tick();
        end
        apply('0);
        chk("sat_stall", 32'(stall_count), 32'(CMAX));
        chk("sat_flush", 32'(flush_count), 32'(CMAX));
        tick();

        // randomized traffic
        do_reset('0);
        for (int n = 0; n < 1500; n++) begin
            r = $urandom;
            x = r[28:0];
            x.id_src1    = 4'($urandom_range(0, 3));
            x.id_src2    = 4'($urandom_range(0, 3));
            x.exe_dest   = 4'($urandom_range(0, 3));
            x.mem_dest   = 4'($urandom_range(0, 3));
            x.wb_dest    = 4'($urandom_range(0, 3));
            x.exe_branch = ($urandom_range(0, 3) == 0);
            x.mem_ready  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset(x);
            end else begin
                apply(x);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
